fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
Shares one single-port framebuffer RAM between two requesters: the display scanout fetch (read-only, latency-critical) and the drawing engine (write-only, car sprite/background updates). Grants at most one RAM access per pixel clock. The display has fixed priority, and the memory-side outputs are registered. Sits between the VGA timing/fetch logic and the framebuffer BRAM.

Parameters:
ADDR_W, 17, framebuffer word address width (320x240 = 76800 words).
DATA_W, 12, pixel width (RGB444).
RD_LATENCY, 1, RAM read latency in cycles, measured from the mem_en sample edge to mem_rdata valid; legal values 1..4.
MAX_WAIT, 16, writer starvation limit in cycles. Used only with the optional feature; legal values 1..255.

Ports:
clk  input  1  pixel clock
rst  input  1  reset, asynchronous, active-high
disp_req  input  1  display read request for this cycle
disp_addr  input  ADDR_W  display read address
disp_gnt  output  1  display request accepted this cycle (combinational)
disp_rvalid  output  1  disp_rdata holds the data for an earlier grant
disp_rdata  output  DATA_W  read data returned to the display
wr_valid  input  1  writer has a pending write
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_ready  output  1  write accepted this cycle (combinational); a transfer occurs when wr_valid=1 and wr_ready=1
mem_en  output  1  RAM enable (registered)
mem_we  output  1  RAM write enable (registered)
mem_addr  output  ADDR_W  RAM address (registered)
mem_wdata  output  DATA_W  RAM write data (registered)
mem_rdata  input  DATA_W  RAM read data
wr_stall_cnt  output  16  count of cycles with wr_valid=1 and wr_ready=0 (saturating)

Behaviour:
- Reset values: mem_en, mem_we, mem_addr, mem_wdata, disp_rvalid, disp_rdata all 0. wr_stall_cnt=0. Owner register = NONE. Wait counter = 0. Read-tag shift register cleared.
- Owner state: one of NONE, DISP, WR. It is registered each cycle from the grant decision and drives the memory registers.
- Grant decision, combinational, every cycle:
  - disp_req=1 and no forced writer slot -> DISP.
  - Otherwise, wr_valid=1 -> WR.
  - Otherwise -> NONE.
- Grant outputs: disp_gnt = (decision==DISP). wr_ready = (decision==WR). wr_ready is never asserted while wr_valid=0.
- Memory registers on each edge:
  - DISP -> en=1, we=0, addr=disp_addr.
  - WR -> en=1, we=1, addr=wr_addr, wdata=wr_data.
  - NONE -> en=0, we=0; addr and wdata hold their previous values.
- Read return:
  - A read tag enters a shift register of depth 1+RD_LATENCY on each DISP grant.
  - disp_rvalid is asserted exactly 1+RD_LATENCY cycles after the disp_gnt cycle.
  - disp_rdata is registered from mem_rdata with that timing, giving total latency grant->rvalid = RD_LATENCY+1. With default RD_LATENCY=1, rvalid arrives 2 cycles after the grant.
  - Back-to-back grants give back-to-back rvalids, in order, with no bubbles.
- Writes are fire-and-forget and produce no response.
- Read-after-write to the same address in consecutive grants: the RAM's own ordering applies, i.e. the read issued after the write returns the new data. The arbiter adds no forwarding.
- wr_stall_cnt increments when wr_valid=1 and wr_ready=0. It saturates at 16'hFFFF and never wraps.
- Simultaneous disp_req and wr_valid without a forced slot: display wins and the writer stalls. wr_data and wr_addr must stay stable until accepted; the bench checks this.
- Reset asserted mid-operation: all in-flight read tags are dropped, so no rvalid is produced for grants issued before reset. The memory registers return to en=0 immediately (asynchronous).

Optional Feature:
Macro FB_ARB_STARVE_GUARD_EN.
- Defined:
  - An 8-bit wait counter increments each cycle that wr_valid=1 and wr_ready=0, and clears on any writer grant or when wr_valid=0.
  - When the counter equals MAX_WAIT, the next decision is a forced WR slot: disp_gnt=0 even if disp_req=1.
  - After the forced grant the counter is 0, so display priority resumes.
- Not defined: strict display priority; the writer can starve indefinitely. The wait counter logic is absent.

Test Plan:
- Reset: rst=1 with random inputs -> all outputs 0. After release with no requests -> mem_en=0 and wr_stall_cnt=0 for 10 cycles.
- Display burst: disp_req=1 for 8 cycles, addresses 100..107, RAM model RD_LATENCY=1 returning data=addr -> disp_gnt=1 for all 8 cycles, mem_addr=100..107 one cycle later, disp_rvalid=1 for 8 consecutive cycles starting 2 cycles after the first grant, disp_rdata=100..107.
- Writer alone: wr_valid=1 for 4 writes, addr 5..8, data 0xABC..0xABF -> wr_ready=1 each cycle, and the RAM model holds those values afterwards. wr_stall_cnt stays 0.
- Contention: disp_req=1 continuously while wr_valid=1 at addr 20 (guard off) -> wr_ready=0 for 50 cycles and wr_stall_cnt=50. Dropping disp_req -> write accepted the same cycle.
- Starvation guard (FB_ARB_STARVE_GUARD_EN, MAX_WAIT=16): same contention -> exactly one cycle with disp_gnt=0 and wr_ready=1, after 16 stalled cycles. The pattern repeats every 17 cycles.
- Reset mid-read: rst pulsed 1 cycle after a DISP grant -> no disp_rvalid follows. The first grant after release returns rvalid at the normal latency.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer RAM between the display
// scanout fetch (read-only, fixed priority) and the drawing engine (write-only).
// At most one RAM access is granted per pixel clock; memory-side outputs are
// registered.
//
// Optional feature: define FB_ARB_STARVE_GUARD_EN to force a writer slot after
// the writer has stalled for MAX_WAIT consecutive cycles. Without it the
// display has strict priority and the writer may starve indefinitely.
//
// Ports:
//   clk, rst                  pixel clock, asynchronous active-high reset
//   disp_req/disp_addr        display read request and address
//   disp_gnt                  display accepted this cycle (combinational)
//   disp_rvalid/disp_rdata    read data, RD_LATENCY+1 cycles after disp_gnt
//   wr_valid/wr_addr/wr_data  pending write from the drawing engine
//   wr_ready                  write accepted this cycle (combinational)
//   mem_en/mem_we/mem_addr/mem_wdata  registered RAM controls
//   mem_rdata                 RAM read data
//   wr_stall_cnt              saturating count of stalled writer cycles
module fb_port_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_WAIT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       wr_stall_cnt
);

  typedef enum logic [1:0] {
    OwnNone,
    OwnDisp,
    OwnWr
  } owner_e;

  owner_e owner_d;
  logic   force_wr;

`ifdef FB_ARB_STARVE_GUARD_EN
  logic [7:0] wait_q;

  // A forced slot only makes sense while a write is actually pending.
  assign force_wr = wr_valid && (wait_q == 8'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 8'd0;
    end else if (!wr_valid || (owner_d == OwnWr)) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_q + 8'd1;
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  // Grant decision; held at NONE during reset so every output reads 0.
  always_comb begin
    owner_d = OwnNone;
    if (!rst) begin
      if (disp_req && !force_wr) begin
        owner_d = OwnDisp;
      end else if (wr_valid) begin
        owner_d = OwnWr;
      end
    end
  end

  assign disp_gnt = (owner_d == OwnDisp);
  assign wr_ready = (owner_d == OwnWr);

  // The {mem_en, mem_we} pair is the registered owner: 00 NONE, 10 DISP, 11 WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (owner_d)
        OwnDisp: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= disp_addr;
        end
        OwnWr: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Read tags: stage 0 loads on the grant edge, the last stage is disp_rvalid.
  // disp_rdata captures mem_rdata on the same edge the tag reaches the end.
  logic [RD_LATENCY:0] tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      disp_rdata <= '0;
    end else begin
      tag_q <= {tag_q[RD_LATENCY-1:0], disp_gnt};
      if (tag_q[RD_LATENCY-1]) begin
        disp_rdata <= mem_rdata;
      end
    end
  end

  assign disp_rvalid = tag_q[RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_stall_cnt <= 16'd0;
    end else if (wr_valid && !wr_ready && (wr_stall_cnt != 16'hFFFF)) begin
      wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter. The main process drives stimulus and
// pushes expected memory-side and read-return responses; a separate monitor
// pops and compares them whenever the DUT presents them.
module tb_fb_port_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 12;
  localparam int unsigned L  = 1;
  localparam int unsigned MW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_req, wr_valid, wr_ready, disp_gnt, disp_rvalid;
  logic [AW-1:0] disp_addr, wr_addr, mem_addr;
  logic [DW-1:0] wr_data, disp_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [15:0]   wr_stall_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fb_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RD_LATENCY(L),
    .MAX_WAIT  (MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .wr_stall_cnt(wr_stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: writes land on the edge that samples mem_we; read data is
  // valid RD_LATENCY edges after the edge that registered mem_en.
  logic [DW-1:0] ram_m [0:(1<<AW)-1];
  always @(posedge clk) if (mem_en && mem_we) ram_m[mem_addr] <= mem_wdata;

  if (L == 1) begin : g_ram1
    assign mem_rdata = ram_m[mem_addr];
  end else begin : g_ramn
    logic [AW-1:0] apipe [0:L-2];
    always @(posedge clk) begin
      apipe[0] <= mem_addr;
      for (int i = 1; i < L - 1; i++) apipe[i] <= apipe[i-1];
    end
    assign mem_rdata = ram_m[apipe[L-2]];
  end

  typedef struct { logic [DW-1:0] data; int due; } rd_exp_t;
  typedef struct {
    logic en; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int due;
  } mem_exp_t;

  rd_exp_t  rd_q[$];
  mem_exp_t mem_q[$];

  // Reference model state: memory contents in grant order, stall/wait counts.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            stall_m, waited;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic          w_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus model update; grants checked mid-cycle.
  task automatic cycle(input logic dreq, input logic [AW-1:0] daddr, input logic wv,
                       input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    logic     force_w, exp_d, exp_w;
    mem_exp_t m;
    @(negedge clk);
    disp_req  = dreq;
    disp_addr = daddr;
    wr_valid  = wv;
    wr_addr   = waddr;
    wr_data   = wdata;
    #1;
`ifdef FB_ARB_STARVE_GUARD_EN
    force_w = wv && (waited >= int'(MW));
`else
    force_w = 1'b0;
`endif
    exp_d = dreq && !force_w;
    exp_w = !exp_d && wv;
    chk("disp_gnt", disp_gnt, exp_d);
    chk("wr_ready", wr_ready, exp_w);
    chk("wr_stall_cnt", wr_stall_cnt, stall_m);
    if (exp_d) begin
      rd_q.push_back('{ref_mem[daddr], cyc + 1 + int'(L)});
      last_addr = daddr;
    end
    if (exp_w) begin
      ref_mem[waddr] = wdata;
      last_addr      = waddr;
      last_wdata     = wdata;
    end
    m.en    = exp_d || exp_w;
    m.we    = exp_w;
    m.addr  = last_addr;
    m.wdata = last_wdata;
    m.due   = cyc + 1;
    mem_q.push_back(m);
    if (wv && !exp_w && stall_m < 65535) stall_m++;
    waited = (wv && !exp_w) ? waited + 1 : 0;
    w_acc  = exp_w;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    disp_req  = 1'($urandom_range(1, 0));
    disp_addr = AW'($urandom);
    wr_valid  = 1'($urandom_range(1, 0));
    wr_addr   = AW'($urandom);
    wr_data   = DW'($urandom);
    rd_q.delete();
    mem_q.delete();
    stall_m    = 0;
    waited     = 0;
    last_addr  = '0;
    last_wdata = '0;
    #1;
    chk("rst_disp_gnt", disp_gnt, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_disp_rvalid", disp_rvalid, 0);
    chk("rst_disp_rdata", disp_rdata, 0);
    chk("rst_wr_stall_cnt", wr_stall_cnt, 0);
    repeat (2) @(negedge clk);
    disp_req = 1'b0;
    wr_valid = 1'b0;
    rst      = 1'b0;
  endtask

  // Monitor: compares registered outputs against queued expectations.
  initial begin
    mem_exp_t m;
    rd_exp_t  r;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        while (mem_q.size() > 0 && mem_q[0].due < cyc) mem_q.delete(0);
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
          m = mem_q.pop_front();
          chk("mem_en", mem_en, m.en);
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wdata", mem_wdata, m.wdata);
        end
        if (disp_rvalid) begin
          if (rd_q.size() == 0) begin
            chk("rvalid_unexpected", disp_rvalid, 0);
          end else begin
            r = rd_q.pop_front();
            chk("disp_rdata", disp_rdata, r.data);
            chk("rvalid_latency", cyc, r.due);
          end
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
          chk("rvalid_missing", disp_rvalid, 1);
          rd_q.delete(0);
        end
      end
    end
  end

  initial begin
    int            n_rdy, n_rv;
    logic          pend;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;

    for (int i = 0; i < (1 << AW); i++) begin
      ram_m[i]   = DW'(i);
      ref_mem[i] = DW'(i);
    end
    disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    stall_m = 0; waited = 0; last_addr = '0; last_wdata = '0; w_acc = 1'b0;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0, '0, '0);
      chk("idle_mem_en", mem_en, 0);
    end

    // Display burst, data = address.
    for (int i = 0; i < 8; i++) cycle(1'b1, AW'(100 + i), 1'b0, '0, '0);
    idle(L + 3);

    // Writer alone.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, AW'(5 + i), DW'(12'hABC + i));
      chk("wr_alone_ready", wr_ready, 1);
    end
    idle(3);
    for (int i = 0; i < 4; i++) chk("ram_after_write", ram_m[5+i], 32'(12'hABC + i));
    chk("stall_after_writes", wr_stall_cnt, 0);

    // Contention: display held high with a pending write at addr 20.
    n_rdy = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, AW'(200 + i), 1'b1, AW'(20), DW'(12'h123));
      if (wr_ready) n_rdy++;
    end
    cycle(1'b0, '0, 1'b1, AW'(20), DW'(12'h123));
    chk("release_wr_ready", wr_ready, 1);
`ifdef FB_ARB_STARVE_GUARD_EN
    chk("contention_ready_cycles", n_rdy, 2);
    chk("contention_stall_cnt", wr_stall_cnt, 48);
`else
    chk("contention_ready_cycles", n_rdy, 0);
    chk("contention_stall_cnt", wr_stall_cnt, 50);
`endif
    idle(L + 3);

    // Reset one cycle after a display grant drops the in-flight read.
    cycle(1'b1, AW'(300), 1'b0, '0, '0);
    do_reset();
    n_rv = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, '0, '0);
      if (disp_rvalid) n_rv++;
    end
    chk("rvalid_after_reset", n_rv, 0);
    cycle(1'b1, AW'(301), 1'b0, '0, '0);
    idle(L + 3);

    // Random traffic on a small address window to hit read-after-write.
    pend = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!pend && $urandom_range(2, 0) != 0) begin
        pend = 1'b1;
        pa   = AW'($urandom_range(15, 0));
        pd   = DW'($urandom);
      end
      cycle($urandom_range(3, 0) != 0, AW'($urandom_range(15, 0)), pend, pa, pd);
      if (w_acc) pend = 1'b0;
    end
    idle(L + 4);
    chk("rd_queue_drained", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
